mem_access_unit: RTL
====================

# mem_access_unit

Memory-access stage of the five-stage pipeline, between the execute/memory pipeline register and the memory/writeback register. It passes ALU, HI/LO results through unchanged. For loads and stores it runs a request/acknowledge transaction on the data bus, holding the pipeline through `stallreq_o` until the transaction completes, aborts on a misaligned address, or times out. Load data is byte/halfword-extracted and sign- or zero-extended before it is written back.

## Interface
Parameters:
- `TIMEOUT`, default 255: bus-wait cycles in BUSY before the access is aborted (8-bit counter; legal range 1..255).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `waddr_reg_i`  in  5  destination register from the EX/MEM register
- `we_reg_i`  in  1  register write enable
- `wdata_i`  in  32  ALU result
- `hi_i`, `lo_i`  in  32 each  HI/LO write values
- `whilo_i`  in  1  HI/LO write enable
- `mem_op_i`  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- `mem_addr_i`  in  32  effective address
- `mem_sdata_i`  in  32  store data (rt)
- `hold_i`  in  1  MEM/WB register is stalled this cycle
- `bus_req_o`, `bus_we_o`  out  1 each  request, write strobe
- `bus_addr_o`  out  32  word-aligned address ({addr[31:2],2'b00})
- `bus_sel_o`  out  4  byte lane enables
- `bus_wdata_o`  out  32  store data on the active lanes
- `bus_ack_i`  in  1  transfer complete
- `bus_rdata_i`  in  32  read data, valid when `bus_ack_i` is high
- `wb_waddr_o`, `wb_we_o`, `wb_wdata_o`, `wb_hi_o`, `wb_lo_o`, `wb_whilo_o`  out  5/1/32/32/32/1  outputs to the MEM/WB register
- `stallreq_o`  out  1  stall request to the stall controller
- `misalign_o`, `bus_err_o`  out  1 each  one-cycle exception flags

## Operation
- Big-endian. Lane 0 (addr[1:0]=0) is bits 31:24, with `bus_sel_o`=4'b1000.
  - Byte: sel=4'b1000>>addr[1:0].
  - Half: addr[1]=0 gives 4'b1100; addr[1]=1 gives 4'b0011.
  - Word: 4'b1111.
  - Store data is replicated across lanes: byte ×4, half ×2.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus cycle is issued.
  - `misalign_o` pulses for 1 cycle.
  - `wb_we_o`=0 for that instruction.
  - No stall is requested.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE, non-memory op: `wb_*` = `*_i` combinationally; `stallreq_o`=0.
  - IDLE, aligned memory op: `stallreq_o`=1 and `wb_we_o`=0. Latch address, sel, we and store data, then go to BUSY.
  - BUSY: `bus_req_o`=1, `stallreq_o`=1, counter increments each cycle.
    - On `bus_ack_i`=1, capture the extended load data and go to DONE.
    - If the counter reaches TIMEOUT without ack, pulse `bus_err_o`, force `wb_we_o`=0 for the instruction, and go to DONE.
  - DONE: `stallreq_o`=0; `wb_*` carry the instruction fields. For loads, `wb_wdata_o` is the captured data.
    - Stay in DONE while `hold_i`=1; otherwise go to IDLE.
- Stores and timed-out accesses drive `wb_we_o` = 0. Loads drive `we_reg_i`. HI/LO fields always pass through.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- `bus_ack_i` outside BUSY is ignored.
- Inputs `*_i` are held stable by the upstream register while `stallreq_o`=1.

## Timing
- Reset (`rst`=0, asynchronous) forces the FSM to IDLE and clears the counter and latches. Until the first clock edge:
  - all `bus_*` outputs = 0;
  - `stallreq_o`, `misalign_o` and `bus_err_o` = 0;
  - `wb_*` follow the IDLE pass-through of the inputs.
- Reset in BUSY drops `bus_req_o` immediately. No completion is reported.
- Non-memory op: 0 added cycles, combinational pass-through.
- Memory op with ack in the first BUSY cycle: 2 stall cycles (IDLE and BUSY). Results appear in DONE on the third cycle.
- Each extra wait cycle adds 1 stall cycle.
- Timeout: `bus_err_o` is high in the BUSY cycle where the counter equals TIMEOUT. DONE follows.
- `bus_req_o` stays high until the cycle ack is sampled, then deasserts on the next edge. Bus outputs are registered.
- Ack and timeout in the same cycle: ack wins, no error.

## Test plan
- Pass-through: ADD result 0x12345678 to r3, `whilo_i`=1, hi=0xA, lo=0xB → same-cycle `wb_*` match, `stallreq_o`=0, no bus request.
- LB at 0x1001, `bus_rdata_i`=0x11F23344, ack in first BUSY cycle:
  - → sel=4'b0100, addr=0x1000;
  - → `wb_wdata_o`=0xFFFFFFF2;
  - → 2 stall cycles.
  - The same access as LBU → 0x000000F2.
- SH at 0x2002 with data 0x0000BEEF, ack after 3 waits → sel=4'b0011, wdata=0xBEEFBEEF, `bus_we_o`=1, `wb_we_o`=0, 5 stall cycles.
- LW at 0x3001 → `misalign_o` pulse, no `bus_req_o`, `wb_we_o`=0, `stallreq_o`=0.
- TIMEOUT=4 with no ack → `bus_err_o` pulses in the 4th BUSY cycle, `wb_we_o`=0, FSM returns to IDLE. Repeat with ack in the 4th cycle → no error.
- Hold and reset:
  - `hold_i`=1 for 2 cycles in DONE → load data held, no second bus request.
  - Assert `rst` in BUSY → `bus_req_o`=0 at once, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: passes ALU/HI/LO results through and runs a
// req/ack data-bus transaction for loads and stores, stalling until it ends.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  waddr_reg_i,
  input  logic        we_reg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic        hold_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic [31:0] wb_wdata_o,
  output logic [31:0] wb_hi_o,
  output logic [31:0] wb_lo_o,
  output logic        wb_whilo_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             bwe_q, bwe_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      bwdata_q, bwdata_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        is_ld_c, is_st_c, is_byte_c, is_half_c, is_word_c, is_mem_c, mis_c;
  logic [3:0]  sel_c;
  logic [31:0] sdata_c;

  function automatic logic op_is_load(logic [3:0] op);
    op_is_load = (op >= OP_LB) && (op <= OP_LW);
  endfunction

  // Big-endian lane extraction followed by sign/zero extension.
  function automatic logic [31:0] load_ext(logic [3:0] op, logic [1:0] lane, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = lane[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0, h};
      default: load_ext = d;
    endcase
  endfunction

  // Operation decode, lane enables and replicated store data.
  always_comb begin
    is_ld_c   = op_is_load(mem_op_i);
    is_st_c   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    is_byte_c = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
    is_half_c = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    is_word_c = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    is_mem_c  = is_ld_c || is_st_c;
    mis_c     = (is_half_c && mem_addr_i[0]) || (is_word_c && (mem_addr_i[1:0] != 2'b00));
    sel_c     = 4'b1111;
    sdata_c   = mem_sdata_i;
    if (is_byte_c) begin
      sel_c   = 4'b1000 >> mem_addr_i[1:0];
      sdata_c = {4{mem_sdata_i[7:0]}};
    end else if (is_half_c) begin
      sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      sdata_c = {2{mem_sdata_i[15:0]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      bwe_q    <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      bwdata_q <= '0;
      op_q     <= '0;
      lane_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      bwe_q    <= bwe_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      bwdata_q <= bwdata_d;
      op_q     <= op_d;
      lane_q   <= lane_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    bwe_d      = bwe_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    bwdata_d   = bwdata_q;
    op_d       = op_q;
    lane_d     = lane_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    wb_waddr_o = waddr_reg_i;
    wb_we_o    = we_reg_i;
    wb_wdata_o = wdata_i;
    wb_hi_o    = hi_i;
    wb_lo_o    = lo_i;
    wb_whilo_o = whilo_i;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem_c && mis_c) begin
          misalign_o = 1'b1;
          wb_we_o    = 1'b0;
        end else if (is_mem_c) begin
          stallreq_o = 1'b1;
          wb_we_o    = 1'b0;
          state_d    = S_BUSY;
          cnt_d      = CNT_W'(1);
          req_d      = 1'b1;
          bwe_d      = is_st_c;
          sel_d      = sel_c;
          addr_d     = {mem_addr_i[31:2], 2'b00};
          bwdata_d   = sdata_c;
          op_d       = mem_op_i;
          lane_d     = mem_addr_i[1:0];
          err_d      = 1'b0;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        wb_we_o    = 1'b0;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack_i) begin
          rdata_d = load_ext(op_q, lane_q, bus_rdata_i);
          req_d   = 1'b0;
          bwe_d   = 1'b0;
          sel_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          bus_err_o = 1'b1;
          err_d     = 1'b1;
          req_d     = 1'b0;
          bwe_d     = 1'b0;
          sel_d     = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        wb_we_o = op_is_load(op_q) && we_reg_i && !err_q;
        if (op_is_load(op_q) && !err_q) begin
          wb_wdata_o = rdata_q;
        end
        if (!hold_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = bwe_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = bwdata_q;

endmodule
